// File: rtl/shell_regaccess_mon_pkg.sv
// Shared definitions for the register-access monitor: register map,
// CTRL/STATUS bit positions, request FSM states and the STATUS layout.
package shell_regaccess_mon_pkg;

  // Word addresses of the register map
  localparam logic [2:0] ADDR_CTRL    = 3'd0;
  localparam logic [2:0] ADDR_STATUS  = 3'd1;
  localparam logic [2:0] ADDR_THRESH  = 3'd2;
  localparam logic [2:0] ADDR_SNAP    = 3'd3;
  localparam logic [2:0] ADDR_LIVE    = 3'd4;
  localparam logic [2:0] ADDR_DELTA   = 3'd5;
  localparam logic [2:0] ADDR_SCRATCH = 3'd6;
  localparam logic [2:0] ADDR_IRQ_EN  = 3'd7;

  // CTRL bit positions
  localparam int CTRL_CMP_EN    = 0;
  localparam int CTRL_SNAP_TRIG = 1;
  localparam int CTRL_CLR       = 2;

  // STATUS bit positions (mirrors status_t below)
  localparam int STATUS_STICKY  = 0;
  localparam int STATUS_OVF     = 1;
  localparam int STATUS_CNT_LSB = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  match_cnt;
    logic [5:0]  rsvd_lo;
    logic        ovf;
    logic        sticky;
  } status_t;

endpackage

// File: rtl/shell_regaccess_mon.sv
// Register-mapped monitor on the upstream free-running count.
// One request/response channel (one transaction in flight), a compare
// path that runs every cycle, snapshots and sticky match status.
// Optional feature: define LOOM_REGMON_IRQ_EN to map IRQ_EN at address 7
// and add the irq_o port.
module shell_regaccess_mon
  import shell_regaccess_mon_pkg::*;
#(
  parameter int AddrWidth = 3,
  parameter int CntMax    = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [31:0]          count_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_write_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_error_o,
  output logic                 match_o
`ifdef LOOM_REGMON_IRQ_EN
  ,
  output logic                 irq_o
`endif
);

  localparam logic [7:0] CNT_MAX = 8'(CntMax);

  state_e      state, state_nxt;
  logic        accept, rsp_done;
  logic [2:0]  addr;
  logic        addr_ok;

  logic        cmp_en;
  logic [31:0] thresh, snap, scratch;
  logic        sticky, ovf;
  logic [7:0]  match_cnt;
`ifdef LOOM_REGMON_IRQ_EN
  logic        irq_en;
`endif

  status_t     status;
  logic [31:0] rd_data;
  logic        rd_err, wr_err;
  logic        wr_en, hit, snap_trig, clr;

  assign accept   = req_valid_i & req_ready_o;
  assign rsp_done = rsp_valid_o & rsp_ready_i;
  assign addr     = req_addr_i[2:0];
  // Any address bit above the 8-word map makes the access unmapped
  assign addr_ok  = (req_addr_i >> 3) == '0;

  // Request FSM: next state and handshake outputs
  always_comb begin
    state_nxt   = state;
    req_ready_o = (state == ST_IDLE);
    rsp_valid_o = (state == ST_RESP);
    case (state)
      ST_IDLE: if (req_valid_i) state_nxt = ST_RESP;
      ST_RESP: if (rsp_ready_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Read mux and error decode, evaluated against pre-accept state
  always_comb begin
    status           = '0;
    status.sticky    = sticky;
    status.ovf       = ovf;
    status.match_cnt = match_cnt;
    rd_data          = '0;
    rd_err           = 1'b0;
    wr_err           = 1'b0;
    case (addr)
      ADDR_CTRL:    rd_data[CTRL_CMP_EN] = cmp_en;
      ADDR_STATUS:  begin rd_data = status;         wr_err = 1'b1; end
      ADDR_THRESH:  rd_data = thresh;
      ADDR_SNAP:    begin rd_data = snap;           wr_err = 1'b1; end
      ADDR_LIVE:    begin rd_data = count_i;        wr_err = 1'b1; end
      ADDR_DELTA:   begin rd_data = count_i - snap; wr_err = 1'b1; end
      ADDR_SCRATCH: rd_data = scratch;
      ADDR_IRQ_EN: begin
`ifdef LOOM_REGMON_IRQ_EN
        rd_data[0] = irq_en;
`else
        rd_err = 1'b1;
        wr_err = 1'b1;
`endif
      end
      default: ;
    endcase
    if (!addr_ok) begin
      rd_data = '0;
      rd_err  = 1'b1;
      wr_err  = 1'b1;
    end
  end

  assign wr_en     = accept & req_write_i & ~wr_err;
  assign snap_trig = wr_en & (addr == ADDR_CTRL) & req_wdata_i[CTRL_SNAP_TRIG];
  assign clr       = wr_en & (addr == ADDR_CTRL) & req_wdata_i[CTRL_CLR];
  assign hit       = cmp_en & (count_i == thresh);

  // Response capture at accept; held until the host takes it
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end else if (accept) begin
      rsp_rdata_o <= req_write_i ? '0 : rd_data;
      rsp_error_o <= req_write_i ? wr_err : rd_err;
    end else if (rsp_done) begin
      rsp_rdata_o <= '0;
      rsp_error_o <= 1'b0;
    end
  end

  // Host-writable configuration registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cmp_en  <= 1'b0;
      thresh  <= '0;
      scratch <= '0;
    end else if (wr_en) begin
      case (addr)
        ADDR_CTRL:    cmp_en  <= req_wdata_i[CTRL_CMP_EN];
        ADDR_THRESH:  thresh  <= req_wdata_i;
        ADDR_SCRATCH: scratch <= req_wdata_i;
        default: ;
      endcase
    end
  end

  // Compare path: snapshot, sticky/overflow flags and saturating hit count.
  // A hit in the same cycle as clr wins and restarts the count at 1.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      snap      <= '0;
      sticky    <= 1'b0;
      ovf       <= 1'b0;
      match_cnt <= '0;
      match_o   <= 1'b0;
    end else begin
      match_o <= hit;
      if (hit || snap_trig) snap <= count_i;
      if (hit) begin
        sticky <= 1'b1;
        if (clr) begin
          ovf       <= 1'b0;
          match_cnt <= 8'd1;
        end else begin
          ovf <= ovf | sticky;
          if (match_cnt != CNT_MAX) match_cnt <= match_cnt + 8'd1;
        end
      end else if (clr) begin
        sticky    <= 1'b0;
        ovf       <= 1'b0;
        match_cnt <= '0;
      end
    end
  end

`ifdef LOOM_REGMON_IRQ_EN
  // IRQ enable register at address 7
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             irq_en <= 1'b0;
    else if (wr_en && addr == ADDR_IRQ_EN) irq_en <= req_wdata_i[0];
  end

  // Level interrupt, one cycle behind sticky/irq_en
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) irq_o <= 1'b0;
    else       irq_o <= sticky & irq_en;
  end
`endif

endmodule

// File: tb/tb_shell_regaccess_mon.sv
// Scoreboard bench for shell_regaccess_mon: a transaction-level model
// predicts each response and the per-cycle handshake/match outputs; a
// separate monitor on the falling edge compares against the DUT.
module tb_shell_regaccess_mon;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] count_i = '0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_write_i = 1'b0;
  logic [2:0]  req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        rsp_valid_o;
  logic        rsp_ready_i = 1'b0;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        match_o;
`ifdef LOOM_REGMON_IRQ_EN
  logic        irq_o;
`endif

  always #5 clk = ~clk;

  shell_regaccess_mon dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .count_i     (count_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_addr_i  (req_addr_i),
    .req_wdata_i (req_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_error_o (rsp_error_o),
    .match_o     (match_o)
`ifdef LOOM_REGMON_IRQ_EN
    ,
    .irq_o       (irq_o)
`endif
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state (register contents as the host sees them)
  logic        m_cmp_en, m_sticky, m_ovf, m_irq_en, m_busy, m_match, m_irq;
  logic [31:0] m_thresh, m_snap, m_scratch;
  int          m_cnt;
  // What the DUT should be presenting right now
  logic        cur_busy, cur_match, cur_irq;
  bit          mon_en  = 1'b0;
  bit          jump_en = 1'b0;
  int          cnt_mod = 128;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cmp_en = 0; m_sticky = 0; m_ovf = 0; m_irq_en = 0; m_busy = 0;
    m_match = 0; m_irq = 0; m_thresh = 0; m_snap = 0; m_scratch = 0; m_cnt = 0;
    cur_busy = 0; cur_match = 0; cur_irq = 0;
    exp_q.delete();
  endtask

  // Predict the effect of the coming rising edge from the inputs now driven
  task automatic model_edge();
    logic acc, hs, hit, werr, wr_ok, snapt, clr, er;
    logic [31:0] rd;
    exp_t e;
    int a;
    a   = int'(req_addr_i);
    acc = req_valid_i && !m_busy;
    hs  = m_busy && rsp_ready_i;
    hit = m_cmp_en && (count_i == m_thresh);
    rd  = '0;
    er  = 1'b0;
    case (a)
      0: rd = {31'b0, m_cmp_en};
      1: rd = {16'b0, 8'(m_cnt), 6'b0, m_ovf, m_sticky};
      2: rd = m_thresh;
      3: rd = m_snap;
      4: rd = count_i;
      5: rd = count_i - m_snap;
      6: rd = m_scratch;
      default: begin
`ifdef LOOM_REGMON_IRQ_EN
        rd = {31'b0, m_irq_en};
`else
        er = 1'b1;
`endif
      end
    endcase
    werr = (a == 1) || (a == 3) || (a == 4) || (a == 5);
`ifndef LOOM_REGMON_IRQ_EN
    if (a == 7) werr = 1'b1;
`endif
    if (acc) begin
      e.rdata = req_write_i ? 32'h0 : rd;
      e.err   = req_write_i ? werr : er;
      exp_q.push_back(e);
    end
    wr_ok = acc && req_write_i && !werr;
    snapt = wr_ok && (a == 0) && req_wdata_i[1];
    clr   = wr_ok && (a == 0) && req_wdata_i[2];
    m_irq = m_sticky & m_irq_en;
    if (hit || snapt) m_snap = count_i;
    if (hit) begin
      if (clr) begin
        m_sticky = 1; m_cnt = 1; m_ovf = 0;
      end else begin
        if (m_sticky) m_ovf = 1;
        m_sticky = 1;
        if (m_cnt < 255) m_cnt++;
      end
    end else if (clr) begin
      m_sticky = 0; m_cnt = 0; m_ovf = 0;
    end
    if (wr_ok) begin
      case (a)
        0: m_cmp_en  = req_wdata_i[0];
        2: m_thresh  = req_wdata_i;
        6: m_scratch = req_wdata_i;
        7: m_irq_en  = req_wdata_i[0];
        default: ;
      endcase
    end
    m_match = hit;
    if (acc)     m_busy = 1;
    else if (hs) m_busy = 0;
  endtask

  // One clock: predict, take the edge, publish expectations, advance counter
  task automatic step();
    model_edge();
    @(posedge clk);
    #2;
    cur_busy  = m_busy;
    cur_match = m_match;
    cur_irq   = m_irq;
    if (jump_en && $urandom_range(0, 31) == 0)
      count_i = 32'($urandom_range(0, cnt_mod - 1));
    else
      count_i = 32'((int'(count_i) + 1) % cnt_mod);
  endtask

  // Issue one request; optionally keep req_valid high while the response stalls
  task automatic xact(input bit wr, input int addr, input logic [31:0] wd,
                      input int stall, input bit hold);
    req_valid_i = 1'b1;
    req_write_i = wr;
    req_addr_i  = 3'(addr);
    req_wdata_i = wd;
    rsp_ready_i = 1'b0;
    step();
    req_valid_i = hold;
    for (int k = 0; k < stall; k++) step();
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
  endtask

  // Monitor: compare presented outputs against the model between edges
  always @(negedge clk) begin
    if (mon_en && !rst_i) begin
      check("req_ready", 32'(req_ready_o), 32'(!cur_busy));
      check("rsp_valid", 32'(rsp_valid_o), 32'(cur_busy));
      check("match", 32'(match_o), 32'(cur_match));
`ifdef LOOM_REGMON_IRQ_EN
      check("irq", 32'(irq_o), 32'(cur_irq));
`endif
      if (rsp_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_rsp: got rdata 0x%08h with nothing pending", rsp_rdata_o);
        end else begin
          check("rsp_rdata", rsp_rdata_o, exp_q[0].rdata);
          check("rsp_error", 32'(rsp_error_o), 32'(exp_q[0].err));
          if (rsp_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check("rst_req_ready", 32'(req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check("rst_rsp_error", 32'(rsp_error_o), 32'd0);
    check("rst_match", 32'(match_o), 32'd0);
    rst_i  = 1'b0;
    mon_en = 1'b1;
    step();

    // Live read at count 20, then a delta against the reset snapshot
    count_i = 32'd20;
    xact(0, 4, 0, 0, 0);
    xact(0, 5, 0, 0, 0);

    // First hit at 100
    xact(1, 2, 32'd100, 0, 0);
    xact(1, 0, 32'd1, 0, 0);
    repeat (130) step();
    xact(0, 3, 0, 0, 0);
    xact(0, 1, 0, 0, 0);

    // Two more wraps past 100, then clr landing on a hit cycle
    repeat (256) step();
    xact(0, 1, 0, 1, 0);
    count_i = 32'd100;
    xact(1, 0, 32'd5, 0, 0);
    xact(0, 1, 0, 0, 0);

    // Stalled response with a second request held pending
    xact(1, 6, 32'hDEADBEEF, 0, 0);
    xact(0, 6, 0, 5, 1);

    // Read-only write and address 7
    xact(1, 3, 32'h1234_5678, 0, 0);
    xact(0, 3, 0, 0, 0);
    xact(0, 7, 0, 0, 0);
    xact(1, 7, 32'd1, 2, 0);
    repeat (140) step();

    // Randomized traffic
    jump_en = 1'b1;
    for (int i = 0; i < 250; i++) begin
      int a;
      logic [31:0] wd;
      a  = $urandom_range(0, 7);
      wd = $urandom;
      if (a == 2) wd = 32'($urandom_range(0, 127));
      if (a == 0) wd = {29'b0, 3'($urandom_range(0, 7)) | 3'b001};
      if (a == 0 && $urandom_range(0, 3) == 0) wd = 32'($urandom_range(0, 7));
      xact(1'($urandom_range(0, 1)), a, wd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end
    jump_en = 1'b0;

    // Reset with a response pending
    req_valid_i = 1'b1; req_write_i = 1'b0; req_addr_i = 3'd4; rsp_ready_i = 1'b0;
    step();
    req_valid_i = 1'b0;
    step();
    rst_i = 1'b1;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
    check("mid_rst_rsp_rdata", rsp_rdata_o, 32'd0);
    check("mid_rst_rsp_error", 32'(rsp_error_o), 32'd0);
    check("mid_rst_match", 32'(match_o), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready_o), 32'd1);
    model_reset();
    rsp_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst_i = 1'b0;
    rsp_ready_i = 1'b0;
    repeat (3) step();
    xact(0, 1, 0, 0, 0);
    xact(0, 6, 0, 0, 0);
    xact(0, 0, 0, 1, 0);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover_rsp: got %0d pending expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
